jt51_lfo_multi: RTL



---
 rtl/jt51_lfo_multi_pkg.sv | 33 +++
 rtl/jt51_lfo_multi_if.sv | 13 +
 rtl/jt51_lfo_multi_shape.sv | 58 +++++
 rtl/jt51_lfo_multi.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/jt51_lfo_multi_pkg.sv
// Shared constants and helpers for the multi-LFO block: waveform codes,
// config register map, noise LFSR definition and phase increment decode.
package jt51_lfo_pkg;

  typedef enum logic [1:0] {
    SAW    = 2'd0,
    SQUARE = 2'd1,
    TRIANG = 2'd2,
    NOISE  = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    REG_FREQ  = 2'd0,
    REG_DEPTH = 2'd1,
    REG_WAVE  = 2'd2,
    REG_SYNC  = 2'd3
  } reg_e;

  localparam logic [16:0] LFSR_SEED  = 17'h1;
  localparam int          LFSR_TAP_A = 16;
  localparam int          LFSR_TAP_B = 13;

  function automatic logic [16:0] lfsr_next(input logic [16:0] s);
    return {s[15:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
  endfunction

  // Mantissa {1,freq[3:0]} scaled by the exponent freq[7:4]; zero freq stops the LFO.
  function automatic logic [19:0] lfo_inc(input logic [7:0] freq);
    if (freq == 8'd0) return '0;
    return 20'({1'b1, freq[3:0]}) << freq[7:4];
  endfunction

endpackage

// File: rtl/jt51_lfo_multi_if.sv
// Configuration write bus of the multi-LFO block.
interface jt51_lfo_multi_if #(
  parameter int N = 2
);
  localparam int AW = $clog2(N) + 2;

  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [7:0]    cfg_din;

  modport master (output cfg_we, cfg_addr, cfg_din);
  modport slave  (input  cfg_we, cfg_addr, cfg_din);
endinterface

// File: rtl/jt51_lfo_multi_shape.sv
// Waveform select and depth scaling for one LFO visit (purely combinational).
module jt51_lfo_shape
  import jt51_lfo_pkg::*;
(
  input  logic [8:0] phase_i,
  input  wave_e      wave_i,
  input  logic [7:0] nreg_i,
  input  logic [6:0] amd_i,
  input  logic [6:0] pmd_i,
  output logic [7:0] am_o,
  output logic [7:0] pm_o
);

  logic        m;
  logic [7:0]  t;
  logic [7:0]  u;
  logic [7:0]  trv;
  logic [7:0]  aw;
  logic [7:0]  pw;
  logic [14:0] am_prod;
  logic signed [15:0] pm_prod;

  assign m   = phase_i[8];
  assign t   = phase_i[8:1];
  assign u   = phase_i[7:0];
  assign trv = m ? ~u : u;

  always_comb begin
    aw = '0;
    pw = '0;
    case (wave_i)
      SAW: begin
        aw = ~t;
        pw = t ^ 8'h80;
      end
      SQUARE: begin
        aw = m ? 8'h00 : 8'hFF;
        pw = m ? 8'h80 : 8'h7F;
      end
      TRIANG: begin
        aw = trv;
        pw = trv ^ 8'h80;
      end
      default: begin
        aw = nreg_i;
        pw = nreg_i ^ 8'h80;
      end
    endcase
  end

  // Depth is 7-bit, so a >>7 keeps the product inside the 8-bit output range.
  assign am_prod = 15'(aw) * 15'(amd_i);
  assign pm_prod = 16'($signed(pw)) * 16'($signed({1'b0, pmd_i}));

  assign am_o = am_prod[14:7];
  assign pm_o = (pmd_i == 7'd0) ? 8'h00 : pm_prod[14:7];

endmodule

// File: rtl/jt51_lfo_multi.sv
// N independent LFOs sharing one time-multiplexed two-stage datapath:
// stage 0 advances the visited phase, stage 1 shapes and scales it.
module jt51_lfo_multi
  import jt51_lfo_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = 22
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  jt51_lfo_multi_if.slave cfg,
  input  logic [1:0]      test,
  output logic [8*N-1:0]  am,
  output logic [8*N-1:0]  pm,
  output logic [N-1:0]    upd
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(N) + 2;

  logic [PW-1:0] phase_q [N];
  logic [PW-1:0] phase_d [N];
  logic [7:0]    freq_q  [N];
  logic [7:0]    freq_d  [N];
  logic [6:0]    amd_q   [N];
  logic [6:0]    amd_d   [N];
  logic [6:0]    pmd_q   [N];
  logic [6:0]    pmd_d   [N];
  wave_e         wave_q  [N];
  wave_e         wave_d  [N];
  logic [7:0]    nreg_q  [N];
  logic [7:0]    nreg_d  [N];
  logic [N-1:0]  pend_q;
  logic [N-1:0]  pend_d;

  logic [16:0]   lfsr_q;
  logic [SW-1:0] slot_q;
  logic          s1_valid_q;
  logic [SW-1:0] s1_slot_q;
  logic [8*N-1:0] am_q;
  logic [8*N-1:0] pm_q;
  logic [N-1:0]  upd_q;

  logic [SW-1:0] wr_idx;
  logic          wr_ok;
  logic [PW-1:0] inc;
  logic [PW:0]   sum;
  logic [8:0]    s1_top;
  logic [7:0]    sh_am;
  logic [7:0]    sh_pm;

  if (N > 1) begin : g_idx
    assign wr_idx = cfg.cfg_addr[AW-1:2];
  end else begin : g_idx1
    assign wr_idx = '0;
  end

  assign wr_ok = cfg.cfg_we && ({1'b0, wr_idx} < (SW+1)'(N));
  assign inc   = PW'(lfo_inc(freq_q[slot_q]));
  assign sum   = {1'b0, phase_q[slot_q]} + {1'b0, inc};

  // Stage 0 for the visited slot, then config writes; a sync write lands after
  // the pending clear so a write racing its own visit waits for the next one.
  always_comb begin
    phase_d = phase_q;
    freq_d  = freq_q;
    amd_d   = amd_q;
    pmd_d   = pmd_q;
    wave_d  = wave_q;
    nreg_d  = nreg_q;
    pend_d  = pend_q;
    if (pend_q[slot_q]) begin
      phase_d[slot_q] = '0;
      pend_d[slot_q]  = 1'b0;
    end else if (!test[0]) begin
      phase_d[slot_q] = sum[PW-1:0];
      if (sum[PW] || test[1]) nreg_d[slot_q] = lfsr_q[7:0];
    end
    if (wr_ok) begin
      case (reg_e'(cfg.cfg_addr[1:0]))
        REG_FREQ:  freq_d[wr_idx] = cfg.cfg_din;
        REG_DEPTH: begin
          if (cfg.cfg_din[7]) pmd_d[wr_idx] = cfg.cfg_din[6:0];
          else                amd_d[wr_idx] = cfg.cfg_din[6:0];
        end
        REG_WAVE:  wave_d[wr_idx] = wave_e'(cfg.cfg_din[1:0]);
        default:   pend_d[wr_idx] = 1'b1;
      endcase
    end
  end

  assign s1_top = phase_q[s1_slot_q][PW-1 -: 9];

  jt51_lfo_shape u_shape (
    .phase_i (s1_top),
    .wave_i  (wave_q[s1_slot_q]),
    .nreg_i  (nreg_q[s1_slot_q]),
    .amd_i   (amd_q[s1_slot_q]),
    .pmd_i   (pmd_q[s1_slot_q]),
    .am_o    (sh_am),
    .pm_o    (sh_pm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '{default: '0};
      freq_q     <= '{default: '0};
      amd_q      <= '{default: '0};
      pmd_q      <= '{default: '0};
      wave_q     <= '{default: SAW};
      nreg_q     <= '{default: '0};
      pend_q     <= '0;
      lfsr_q     <= LFSR_SEED;
      slot_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_slot_q  <= '0;
      am_q       <= '0;
      pm_q       <= '0;
      upd_q      <= '0;
    end else if (cen) begin
      phase_q    <= phase_d;
      freq_q     <= freq_d;
      amd_q      <= amd_d;
      pmd_q      <= pmd_d;
      wave_q     <= wave_d;
      nreg_q     <= nreg_d;
      pend_q     <= pend_d;
      lfsr_q     <= lfsr_next(lfsr_q);
      slot_q     <= (slot_q == SW'(N-1)) ? '0 : slot_q + 1'b1;
      s1_valid_q <= 1'b1;
      s1_slot_q  <= slot_q;
      if (s1_valid_q) begin
        am_q[8*s1_slot_q +: 8] <= sh_am;
        pm_q[8*s1_slot_q +: 8] <= sh_pm;
        upd_q <= N'(1) << s1_slot_q;
      end else begin
        upd_q <= '0;
      end
    end
  end

  assign am  = am_q;
  assign pm  = pm_q;
  assign upd = upd_q;

endmodule
